// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan controller.
//   HEX_SEG  : 16-entry nibble -> segment table, active-high, bit order {g,f,e,d,c,b,a}
//   SEG_OFF  : active-high "all segments dark" pattern
//   clog2    : ceiling log2 for sizing counters from parameters
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to seven-segment decoder.
//   nibble  : 4-bit hex value
//   pattern : active-high segments {g,f,e,d,c,b,a}
// Output polarity is left to the caller.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed seven-segment driver.
//   clk        : board clock
//   reset      : asynchronous, active-low
//   data_in    : DIGITS hex nibbles, digit 0 in [3:0] (rightmost)
//   data_valid : one-cycle strobe capturing data_in/lz_blank into the pending register
//   lz_blank   : blank leading zero digits (digit 0 never blanked)
//   seg        : registered segments {g,f,e,d,c,b,a}, polarity set by ACTIVE_LOW
//   an         : registered digit enables, one-hot while lit
//   frame_tick : one-cycle pulse in the first cycle of each digit-0 slot
//   pending    : captured data is waiting for the next frame boundary
// Optional feature macro SEG7_DP_EN adds dp_in[DIGITS-1:0] (captured with
// data_in) and a dp output with the same polarity as seg.
//
// Handshake: data_valid has no back-pressure. Every cycle it is high is
// accepted into the pending register (last write wins); the pending word is
// copied to the display register only on a frame boundary so a frame never
// mixes old and new digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 100000,
  parameter int GUARD      = 16,
  parameter bit ACTIVE_LOW = 1'b1
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  data_valid,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  pending
`ifdef SEG7_DP_EN
  ,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  dp
`endif
);

  localparam int PW = clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  // XOR masks that convert active-high internals to pin polarity.
  localparam logic [6:0]        SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_POL  = {DIGITS{ACTIVE_LOW}};

  // ---------------------------------------------------------------------------
  // Scan timebase
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          presc_wrap;
  logic          frame_edge;

  assign presc_wrap = (presc == PRESC_MAX);
  // The edge that returns the index to 0 is the frame boundary.
  assign frame_edge = presc_wrap && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      if (presc_wrap) begin
        presc <= '0;
        idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending and display registers
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] pend_nib;
  logic                pend_lz;
  logic [4*DIGITS-1:0] disp_nib;
  logic                disp_lz;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   disp_dp;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_nib   <= '0;
      pend_lz    <= 1'b0;
      disp_nib   <= '0;
      disp_lz    <= 1'b0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
`ifdef SEG7_DP_EN
      pend_dp    <= '0;
      disp_dp    <= '0;
`endif
    end else begin
      frame_tick <= frame_edge;
      // Commit uses the value already pending; a strobe on the same edge
      // becomes the next pending value.
      if (frame_edge && pending) begin
        disp_nib <= pend_nib;
        disp_lz  <= pend_lz;
`ifdef SEG7_DP_EN
        disp_dp  <= pend_dp;
`endif
      end
      if (data_valid) begin
        pend_nib <= data_in;
        pend_lz  <= lz_blank;
        pending  <= 1'b1;
`ifdef SEG7_DP_EN
        pend_dp  <= dp_in;
`endif
      end else if (frame_edge) begin
        pending  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking: walk down from the most significant digit while
  // every digit seen so far is zero.
  // ---------------------------------------------------------------------------
  logic [DIGITS-1:0] digit_nz;
  logic [DIGITS-1:0] blank;
  logic              upper_zero;

  always_comb begin
    digit_nz   = '0;
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef SEG7_DP_EN
      digit_nz[k] = (|disp_nib[4*k +: 4]) | disp_dp[k];
`else
      digit_nz[k] = |disp_nib[4*k +: 4];
`endif
    end
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & ~digit_nz[k];
      blank[k]   = disp_lz & upper_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Current-digit selection
  // ---------------------------------------------------------------------------
  logic [3:0]        cur_nib;
  logic              cur_blank;
  logic [DIGITS-1:0] cur_onehot;
`ifdef SEG7_DP_EN
  logic              cur_dp;
`endif

  always_comb begin
    cur_nib    = '0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
`ifdef SEG7_DP_EN
    cur_dp     = 1'b0;
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib       = disp_nib[4*k +: 4];
        cur_blank     = blank[k];
        cur_onehot[k] = 1'b1;
`ifdef SEG7_DP_EN
        cur_dp        = disp_dp[k];
`endif
      end
    end
  end

  logic [6:0] cur_pattern;

  hex_to_seg7 u_dec (
    .nibble  (cur_nib),
    .pattern (cur_pattern)
  );

  // Anodes stay dark for the first GUARD cycles of each slot so the previous
  // digit's segments cannot ghost onto the new anode.
  logic in_guard;

  generate
    if (GUARD > 0) begin : g_guard
      assign in_guard = (presc < PW'(GUARD));
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  logic [6:0]        seg_hi;
  logic [DIGITS-1:0] an_hi;

  always_comb begin
    seg_hi = cur_blank ? SEG_OFF : cur_pattern;
    an_hi  = (in_guard || cur_blank) ? '0 : cur_onehot;
  end

  // ---------------------------------------------------------------------------
  // Registered pin drivers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_OFF ^ SEG_POL;
      an  <= AN_POL;
`ifdef SEG7_DP_EN
      dp  <= ACTIVE_LOW;
`endif
    end else begin
      seg <= seg_hi ^ SEG_POL;
      an  <= an_hi ^ AN_POL;
`ifdef SEG7_DP_EN
      dp  <= (cur_dp & ~cur_blank) ^ ACTIVE_LOW;
`endif
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: self-checking bench for seg7_scan_ctrl.
// u_dut : DIGITS=4, PRESCALE=4, GUARD=1, active-low (frame = 16 cycles)
// u_one : DIGITS=1, PRESCALE=3, GUARD=0, active-low
module tb_seg7_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int GUARD    = 1;
  localparam int N        = DIGITS * PRESCALE;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] data_in    = '0;
  logic        data_valid = 1'b0;
  logic        lz_blank   = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  logic [3:0]  data_in1 = '0;
  logic [6:0]  seg1;
  logic [0:0]  an1;
  logic        tick1;
  logic        pend1;

`ifdef SEG7_DP_EN
  logic [3:0]  dp_in  = '0;
  logic        dp;
  logic [0:0]  dp_in1 = '0;
  logic        dp1;
`endif

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .GUARD(GUARD), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .pending    (pending)
`ifdef SEG7_DP_EN
    ,
    .dp_in      (dp_in),
    .dp         (dp)
`endif
  );

  seg7_scan_ctrl #(
    .DIGITS(1), .PRESCALE(3), .GUARD(0), .ACTIVE_LOW(1'b1)
  ) u_one (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in1),
    .data_valid (1'b0),
    .lz_blank   (1'b0),
    .seg        (seg1),
    .an         (an1),
    .frame_tick (tick1),
    .pending    (pend1)
`ifdef SEG7_DP_EN
    ,
    .dp_in      (dp_in1),
    .dp         (dp1)
`endif
  );

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: digits decoded from the word by plain arithmetic
  // ---------------------------------------------------------------------------
  logic [6:0] seg_ref [16];
  initial begin
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Returns {an, seg} at pin polarity for the given word {lz, nibbles}.
  function automatic logic [10:0] ref_out(input logic [16:0] w, input int slot, input int phase);
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  s;
    logic [3:0]  a;
    upper = w[15:0] >> (4 * slot);
    nib   = upper[3:0];
    blank = w[16] && (slot > 0) && (upper == 16'h0);
    s     = blank ? 7'h00 : seg_ref[nib];
    a     = (blank || phase < GUARD) ? 4'h0 : 4'(1 << slot);
    return {~a, ~s};
  endfunction

  logic        go       = 1'b0;
  logic        stop     = 1'b0;
  logic        mon_done = 1'b0;
  int          edge_n   = 0;
  logic        m_pend   = 1'b0;
  logic [16:0] m_pend_val = '0;
  logic [16:0] m_disp     = '0;
  logic [16:0] exp_q[$];

  // Model: every N-th edge after reset release is a frame boundary; the word
  // shown for the following frame is pushed onto the scoreboard queue.
  initial begin
    wait (go);
    forever begin
      @(posedge clk);
      edge_n++;
      if (edge_n % N == 0) begin
        if (m_pend) m_disp = m_pend_val;
        m_pend = 1'b0;
        exp_q.push_back(m_disp);
      end
      if (data_valid) begin
        m_pend     = 1'b1;
        m_pend_val = {lz_blank, data_in};
      end
      @(negedge clk);
      check("pending", pending, m_pend);
      check("one_tick", tick1, (edge_n % 3) == 0);
      check("one_an", an1, 1'b0);
      check("one_seg", seg1, 7'h40);
      check("one_pending", pend1, 1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops one expected word per frame_tick and checks every cycle
  // ---------------------------------------------------------------------------
  initial begin
    int          cnt;
    logic [16:0] w;
    logic [10:0] e;
    wait (go);
    cnt = 0;
    while (!frame_tick && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("first_tick", frame_tick, 1'b1);
    while (!stop) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 32'd0, 32'd1);
        break;
      end
      w = exp_q.pop_front();
      for (int j = 1; j <= N; j++) begin
        @(negedge clk);
        e = ref_out(w, (j - 1) / PRESCALE, (j - 1) % PRESCALE);
        check("seg", seg, e[6:0]);
        check("an", an, e[10:7]);
        check("frame_tick", frame_tick, j == N);
      end
    end
    mon_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic strobe_at(input int e, input logic [15:0] d, input logic lz);
    while (edge_n < e - 1) @(negedge clk);
    data_in    = d;
    lz_blank   = lz;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  logic [15:0] masks [5];
  initial masks = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0F0F, 16'h0000};

  initial begin
    int e1;
    int e2;
    int ns;
    int cnt;

    // Reset held from time 0.
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_pending", pending, 1'b0);

    // Run briefly with pending data, then drop reset between clock edges.
    reset = 1'b1;
    @(negedge clk);
    data_in = 16'hBEEF; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_pending", pending, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_an", an, 4'hF);
    check("async_rst_tick", frame_tick, 1'b0);
    check("async_rst_pending", pending, 1'b0);
    check("async_rst_one_seg", seg1, 7'h7F);
    check("async_rst_one_an", an1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    go    = 1'b1;

    // Directed frames.
    strobe_at(3,  16'h12AF, 1'b0);   // frame 1: 12AF
    strobe_at(20, 16'h0005, 1'b1);   // frame 2: 0005 with blanking
    strobe_at(40, 16'h0005, 1'b0);   // frame 3: 0005 unblanked
    strobe_at(50, 16'h1111, 1'b0);   // overwritten before commit
    strobe_at(55, 16'h2222, 1'b0);   // frame 4: 2222
    strobe_at(70, 16'h3333, 1'b0);   // frame 5: 3333
    strobe_at(80, 16'h4444, 1'b1);   // on the boundary edge: frame 6

    // Randomised frames, including strobes on boundary edges.
    for (int f = 7; f < 19; f++) begin
      ns = $urandom_range(0, 2);
      e1 = N * f + $urandom_range(1, 8);
      e2 = e1 + $urandom_range(1, 8);
      if (ns >= 1)
        strobe_at(e1, 16'($urandom) & masks[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
      if (ns >= 2)
        strobe_at(e2, 16'($urandom) & masks[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
    end

    while (edge_n < N * 21) @(negedge clk);
    stop = 1'b1;
    cnt  = 0;
    while (!mon_done && cnt < 4 * N) begin
      @(negedge clk);
      cnt++;
    end
    check("monitor_done", mon_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment driver for the board-level wrapper. It replaces the fixed 4-digit display instance: any digit count, configurable refresh rate and anti-ghosting guard time. New data is accepted through a valid strobe and committed only at frame boundaries, so the display never tears. It sits between the CPU-visible show word and the board's seg/an pins, clocked from the raw board clock.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE, 100000, clock cycles per digit slot (>= GUARD+2)
GUARD, 16, cycles at the start of each slot with all anodes off (anti-ghosting; 0 = none)
ACTIVE_LOW, 1, 1: seg/an driven active-low (Basys3); 0: active-high

Ports:
clk  in  1  board clock
reset  in  1  asynchronous, active-low reset
data_in  in  4*DIGITS  hex nibbles; digit 0 = bits [3:0], digit 0 is rightmost
data_valid  in  1  one-cycle strobe; captures data_in and lz_blank into a pending register
lz_blank  in  1  1 = blank leading zero digits (the most significant digits down to digit 1; digit 0 is never blanked)
seg  out  7  segments {g,f,e,d,c,b,a}
an  out  DIGITS  digit enables, one-hot while lit
frame_tick  out  1  one-cycle pulse when the display register is reloaded (start of digit 0 slot)
pending  out  1  1 while captured data awaits commit

Behaviour:
- Reset (async, reset=0): prescaler=0, digit index=0, display reg=0, pending reg=0, pending=0, frame_tick=0, an=all off, seg=all off (all ones if ACTIVE_LOW).
- Prescaler counts 0..PRESCALE-1, then wraps. Wrap from PRESCALE-1 advances the digit index; index DIGITS-1 wraps to 0.
- The cycle in which the index becomes 0 is the frame boundary.
  - If pending=1, display reg <= pending reg and pending clears.
  - frame_tick pulses for 1 cycle on every frame boundary, including boundaries with no new data.
- data_valid=1: pending reg <= {lz_blank, data_in} and pending=1 on the next edge.
  - A later strobe before commit overwrites the earlier one (last wins).
  - A strobe coinciding with a commit: the old pending value commits and the new value becomes pending (pending stays 1).
- Output timing: seg/an are registered and change one cycle after the index or prescaler changes.
  - While prescaler < GUARD: an = all off; seg keeps the new digit's pattern.
  - While prescaler >= GUARD: an = one-hot at the index, unless that digit is blanked.
- Leading-zero blanking: digit k is blanked when lz_blank=1, k>0, and nibbles k..DIGITS-1 are all zero.
  - A blanked digit holds an off for the whole slot; seg is all off.
- Decode (active-high form, inverted when ACTIVE_LOW): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Widths: prescaler is clog2(PRESCALE) bits; index is clog2(DIGITS) bits, minimum 1. DIGITS=1 gives a permanent index 0 and a frame boundary every slot.

Optional Feature:
SEG7_DP_EN
- Defined: adds port dp_in [DIGITS-1:0], captured together with data_in, and output dp (1 bit, same polarity as seg).
  - dp shows the dp bit of the current digit, with the same guard and blanking rules.
  - Blanking treats a digit whose dp bit is set as non-zero.
- Undefined: no dp ports or state; blanking uses nibbles only.

Decomposition:
- Package seg7_pkg:
  - hex-to-segment constant table (16 x 7, active-high)
  - SEG_OFF constant
  - clog2 helper function
- One sub-module, hex_to_seg7: combinational nibble to 7-bit active-high pattern. Instantiated once on the muxed nibble; polarity is applied in the parent's output register.

Test Plan:
1. Reset low mid-count with DIGITS=4, PRESCALE=4, GUARD=1, ACTIVE_LOW=1 -> seg=7F and an=F immediately, with no clock edge required.
2. Strobe data_in=16'h12AF, lz_blank=0 -> commit at next frame_tick. Each slot shows an=F for 1 cycle, then an=E with seg=0E (F), D with 08 (A), B with 24 (2), 7 with 79 (1).
3. data_in=16'h0005, lz_blank=1 -> digit 0 shows seg=12 with an=E; digits 1..3 keep an=F and seg=7F all slot. Same data with lz_blank=0 -> digits 1..3 show seg=40.
4. Strobe 16'h1111, then 16'h2222 before the boundary -> pending=1 until the boundary, and only 2222 is ever displayed.
5. Strobe asserted exactly on the frame-boundary cycle with pending=1 -> the older value is displayed and the new value stays pending; it commits at the next frame_tick, one frame later (16 cycles).
6. DIGITS=1, PRESCALE=3, GUARD=0 -> an=0 continuously after the first slot; frame_tick every 3 cycles.
